// File: rtl/gray_pkg.sv
// Shared types and defaults for the Gray-code monitor family.
package gray_pkg;

   localparam int GRAY_WIDTH = 3;

   typedef enum logic [1:0] {
      SYNC,
      LOCKED,
      FAULT
   } gm_state_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   always_comb begin
      bin_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin_o[i] = ^(gray_i >> i);
      end
   end

endmodule

// File: rtl/gray_monitor.sv
// Samples a Gray-coded counter stream, converts it to binary and checks every advance is a legal +1 step,
// counting wraps and illegal steps in saturating counters.
module gray_monitor
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_b,
   input  logic             valid,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             clear,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             locked,
   output logic             step_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] wrap_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [WIDTH-1:0] BIN_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   gm_state_t        state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             binValid_q, binValid_d;
   logic             stepErr_q, stepErr_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] wrap_q, wrap_d;
   logic [CNT_W-1:0] errCnt_q, errCnt_d;

   logic [WIDTH-1:0] sampleBin;
   logic [WIDTH-1:0] expectBin;

   gray2bin #(
      .WIDTH(WIDTH)
   ) u_gray2bin (
      .gray_i(gray_in),
      .bin_o (sampleBin)
   );

   assign expectBin = prev_q + WIDTH'(1);

   // Clear outranks a concurrent sample; the sample is dropped and bin_out keeps its old value.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      bin_d      = bin_q;
      binValid_d = 1'b0;
      stepErr_d  = 1'b0;
      sticky_d   = sticky_q;
      wrap_d     = wrap_q;
      errCnt_d   = errCnt_q;

      if (clear) begin
         state_d  = SYNC;
         wrap_d   = '0;
         errCnt_d = '0;
         sticky_d = 1'b0;
      end else if (valid) begin
         prev_d     = sampleBin;
         bin_d      = sampleBin;
         binValid_d = 1'b1;
         case (state_q)
            SYNC, FAULT: state_d = LOCKED;
            LOCKED: begin
               if (sampleBin == expectBin) begin
                  if (prev_q == BIN_MAX && wrap_q != CNT_MAX) begin
                     wrap_d = wrap_q + CNT_W'(1);
                  end
               end else if (sampleBin != prev_q) begin
                  stepErr_d = 1'b1;
                  sticky_d  = 1'b1;
                  state_d   = FAULT;
                  if (errCnt_q != CNT_MAX) begin
                     errCnt_d = errCnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_d = SYNC;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state_q    <= SYNC;
         prev_q     <= '0;
         bin_q      <= '0;
         binValid_q <= 1'b0;
         stepErr_q  <= 1'b0;
         sticky_q   <= 1'b0;
         wrap_q     <= '0;
         errCnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         bin_q      <= bin_d;
         binValid_q <= binValid_d;
         stepErr_q  <= stepErr_d;
         sticky_q   <= sticky_d;
         wrap_q     <= wrap_d;
         errCnt_q   <= errCnt_d;
      end
   end

   assign bin_out    = bin_q;
   assign bin_valid  = binValid_q;
   assign locked     = (state_q == LOCKED);
   assign step_err   = stepErr_q;
   assign err_sticky = sticky_q;
   assign wrap_count = wrap_q;
   assign err_count  = errCnt_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Directed bench for gray_monitor; a second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_gray_monitor;

   logic       clock;
   logic       reset_b;
   logic       valid;
   logic [2:0] gray_in;
   logic       clear;

   logic [2:0] bin_out;
   logic       bin_valid, locked, step_err, err_sticky;
   logic [7:0] wrap_count, err_count;

   logic [2:0] satBin;
   logic       satBinValid, satLocked, satStepErr, satSticky;
   logic [1:0] satWrap, satErr;

   int checks;
   int errors;

   gray_monitor #(.WIDTH(3), .CNT_W(8)) dut (
      .clock(clock), .reset_b(reset_b), .valid(valid), .gray_in(gray_in), .clear(clear),
      .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked), .step_err(step_err),
      .err_sticky(err_sticky), .wrap_count(wrap_count), .err_count(err_count)
   );

   gray_monitor #(.WIDTH(3), .CNT_W(2)) dutSat (
      .clock(clock), .reset_b(reset_b), .valid(valid), .gray_in(gray_in), .clear(clear),
      .bin_out(satBin), .bin_valid(satBinValid), .locked(satLocked), .step_err(satStepErr),
      .err_sticky(satSticky), .wrap_count(satWrap), .err_count(satErr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
   task automatic applyStimulus(input logic [2:0] g, input logic v, input logic c);
      @(negedge clock);
      gray_in = g;
      valid   = v;
      clear   = c;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_b = 1'b0;
      valid   = 1'b0;
      clear   = 1'b0;
      gray_in = 3'b000;
      #3;
      checks++;
      if ({bin_out, bin_valid, locked, step_err, err_sticky, wrap_count, err_count} !== 23'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {bin_out, bin_valid, locked, step_err, err_sticky, wrap_count, err_count});
      end
      @(negedge clock);
      reset_b = 1'b1;
   endtask

   task automatic test_legal_loop();
      logic [2:0] seq [8];
      logic [7:0] expWrap;
      seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
      for (int n = 0; n < 17; n++) begin
         applyStimulus(seq[n % 8], 1'b1, 1'b0);
         expWrap = (n >= 16) ? 8'd2 : (n >= 8) ? 8'd1 : 8'd0;
         checks++;
         if (bin_out !== 3'(n % 8)) begin
            errors++; $display("[TB] FAIL loop_bin n=%0d: got %0d expected %0d", n, bin_out, n % 8);
         end
         checks++;
         if (bin_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL loop_bin_valid n=%0d: got %b expected 1", n, bin_valid);
         end
         checks++;
         if (step_err !== 1'b0) begin
            errors++; $display("[TB] FAIL loop_step_err n=%0d: got %b expected 0", n, step_err);
         end
         checks++;
         if (wrap_count !== expWrap) begin
            errors++; $display("[TB] FAIL loop_wrap n=%0d: got %0d expected %0d", n, wrap_count, expWrap);
         end
         if (n >= 1) begin
            checks++;
            if (locked !== 1'b1) begin
               errors++; $display("[TB] FAIL loop_locked n=%0d: got %b expected 1", n, locked);
            end
         end
      end
   endtask

   task automatic test_hold_gaps();
      applyStimulus(3'b001, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(3'b011, 1'b1, 1'b0);
         checks++;
         if ({bin_out, bin_valid, step_err} !== {3'd2, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL hold_sample k=%0d: got bin=%0d v=%b err=%b expected bin=2 v=1 err=0",
                               k, bin_out, bin_valid, step_err);
         end
         applyStimulus(3'b011, 1'b0, 1'b0);
         checks++;
         if ({bin_out, bin_valid, step_err} !== {3'd2, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL hold_gap k=%0d: got bin=%0d v=%b err=%b expected bin=2 v=0 err=0",
                               k, bin_out, bin_valid, step_err);
         end
      end
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("[TB] FAIL hold_locked: got %b expected 1", locked);
      end
   endtask

   task automatic test_illegal_skip();
      applyStimulus(3'b000, 1'b0, 1'b1);
      checks++;
      if ({wrap_count, locked} !== {8'd0, 1'b0}) begin
         errors++; $display("[TB] FAIL clear_idle: got wrap=%0d locked=%b expected wrap=0 locked=0", wrap_count, locked);
      end
      applyStimulus(3'b001, 1'b1, 1'b0);
      applyStimulus(3'b010, 1'b1, 1'b0);
      checks++;
      if ({step_err, err_count, err_sticky, locked, bin_out} !== {1'b1, 8'd1, 1'b1, 1'b0, 3'd3}) begin
         errors++; $display("[TB] FAIL skip_flag: got err=%b cnt=%0d sticky=%b locked=%b bin=%0d expected 1 1 1 0 3",
                            step_err, err_count, err_sticky, locked, bin_out);
      end
      applyStimulus(3'b110, 1'b1, 1'b0);
      checks++;
      if ({step_err, err_count, err_sticky, locked, bin_out} !== {1'b0, 8'd1, 1'b1, 1'b1, 3'd4}) begin
         errors++; $display("[TB] FAIL skip_relock: got err=%b cnt=%0d sticky=%b locked=%b bin=%0d expected 0 1 1 1 4",
                            step_err, err_count, err_sticky, locked, bin_out);
      end
   endtask

   task automatic test_saturation();
      logic [2:0] badGray [5];
      logic [1:0] expSat;
      badGray = '{3'b011, 3'b110, 3'b101, 3'b000, 3'b011};
      applyStimulus(3'b000, 1'b0, 1'b1);
      applyStimulus(3'b000, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(badGray[k], 1'b1, 1'b0);
         expSat = (k >= 2) ? 2'd3 : 2'(k + 1);
         checks++;
         if ({satStepErr, satErr, satSticky} !== {1'b1, expSat, 1'b1}) begin
            errors++; $display("[TB] FAIL sat_err k=%0d: got err=%b cnt=%0d sticky=%b expected 1 %0d 1",
                               k, satStepErr, satErr, satSticky, expSat);
         end
         checks++;
         if (err_count !== 8'(k + 1)) begin
            errors++; $display("[TB] FAIL sat_wide_cnt k=%0d: got %0d expected %0d", k, err_count, k + 1);
         end
         applyStimulus(badGray[k], 1'b1, 1'b0);
         checks++;
         if ({satStepErr, satLocked} !== {1'b0, 1'b1}) begin
            errors++; $display("[TB] FAIL sat_relock k=%0d: got err=%b locked=%b expected 0 1", k, satStepErr, satLocked);
         end
      end
   endtask

   task automatic test_clear_with_valid();
      applyStimulus(3'b111, 1'b1, 1'b1);
      checks++;
      if ({wrap_count, err_count, err_sticky, locked, bin_valid, bin_out, step_err} !==
          {8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0}) begin
         errors++; $display("[TB] FAIL clear_valid: got wrap=%0d cnt=%0d sticky=%b locked=%b v=%b bin=%0d err=%b expected 0 0 0 0 0 2 0",
                            wrap_count, err_count, err_sticky, locked, bin_valid, bin_out, step_err);
      end
      checks++;
      if ({satErr, satSticky} !== {2'd0, 1'b0}) begin
         errors++; $display("[TB] FAIL clear_sat: got cnt=%0d sticky=%b expected 0 0", satErr, satSticky);
      end
      applyStimulus(3'b100, 1'b1, 1'b0);
      checks++;
      if ({step_err, locked, bin_out, err_count} !== {1'b0, 1'b1, 3'd7, 8'd0}) begin
         errors++; $display("[TB] FAIL clear_resync: got err=%b locked=%b bin=%0d cnt=%0d expected 0 1 7 0",
                            step_err, locked, bin_out, err_count);
      end
   endtask

   task automatic test_async_reset();
      applyStimulus(3'b001, 1'b1, 1'b0);
      applyStimulus(3'b001, 1'b1, 1'b0);
      checks++;
      if ({locked, err_sticky, err_count} !== {1'b1, 1'b1, 8'd1}) begin
         errors++; $display("[TB] FAIL pre_reset: got locked=%b sticky=%b cnt=%0d expected 1 1 1", locked, err_sticky, err_count);
      end
      @(negedge clock);
      valid = 1'b0;
      #2 reset_b = 1'b0;
      #1;
      checks++;
      if ({bin_out, bin_valid, locked, step_err, err_sticky, wrap_count, err_count} !== 23'd0) begin
         errors++; $display("[TB] FAIL async_reset: got %h expected 0",
                            {bin_out, bin_valid, locked, step_err, err_sticky, wrap_count, err_count});
      end
      @(negedge clock);
      reset_b = 1'b1;
      applyStimulus(3'b101, 1'b1, 1'b0);
      checks++;
      if ({bin_out, bin_valid, step_err, locked, err_count} !== {3'd6, 1'b1, 1'b0, 1'b1, 8'd0}) begin
         errors++; $display("[TB] FAIL post_reset: got bin=%0d v=%b err=%b locked=%b cnt=%0d expected 6 1 0 1 0",
                            bin_out, bin_valid, step_err, locked, err_count);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_legal_loop();
      test_hold_gaps();
      test_illegal_skip();
      test_saturation();
      test_clear_with_valid();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
